// File: rtl/uart_rx_os16.sv
// 16x-oversampling UART receiver with an internal tick divider, single clock domain.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling at sub 7/8/9.
module uart_rx_os16 #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_ON  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BIT   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  busy
);
    localparam int OS_DIV = CLK_FREQ / (BAUD_RATE * 16);
    localparam int DIV_W  = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
    localparam int IDX_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(OS_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);
    localparam logic             PAR_ODD   = (PARITY_ODD != 0);
    localparam logic             LAST_STOP = (STOP_BIT == 2);
    localparam logic [3:0]       SUB_LAST  = 4'd15;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                  state, state_n;
    logic                    rx_m, rx_s;
    logic [DIV_W-1:0]        div_cnt;
    logic                    tick;
    logic [3:0]              sub;
    logic [IDX_W-1:0]        idx;
    logic [DATA_WIDTH-1:0]   shift;
    logic                    perr, ferr, ferr_n;
    logic                    stop_idx;
    logic                    armed;
    logic                    bit_val;
    logic                    sample, bit_end, done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // With OS_DIV=1 the counter is stuck at 0 == DIV_LAST, so tick stays high.
    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 1'b1;
    end

`ifdef UART_RX_MAJORITY_EN
    localparam logic [3:0] SUB_SAMPLE = 4'd9;
    logic s7, s8;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s7 <= 1'b1;
            s8 <= 1'b1;
        end else if (tick) begin
            if (sub == 4'd7) s7 <= rx_s;
            if (sub == 4'd8) s8 <= rx_s;
        end
    end

    assign bit_val = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
`else
    localparam logic [3:0] SUB_SAMPLE = 4'd8;

    assign bit_val = rx_s;
`endif

    assign sample  = tick && (sub == SUB_SAMPLE);
    assign bit_end = tick && (sub == SUB_LAST);
    assign ferr_n  = ferr | ~bit_val;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        done    = 1'b0;
        case (state)
            IDLE:   if (tick && armed && !rx_s) state_n = START;
            START: begin
                if (sample && bit_val) state_n = IDLE;
                else if (bit_end)      state_n = DATA;
            end
            DATA:   if (bit_end && idx == IDX_LAST) state_n = (PARITY_ON != 0) ? PARITY : STOP;
            PARITY: if (bit_end) state_n = STOP;
            STOP: begin
                // Leave at mid-stop so a following start edge is never missed.
                if (sample && stop_idx == LAST_STOP) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub        <= '0;
            idx        <= '0;
            shift      <= '0;
            perr       <= 1'b0;
            ferr       <= 1'b0;
            stop_idx   <= 1'b0;
            armed      <= 1'b0;
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            valid <= 1'b0;

            if (state == IDLE) sub <= '0;
            else if (tick)     sub <= sub + 1'b1;

            // A framing error disarms so a held-low break is not taken as a new start.
            if (done && ferr_n)     armed <= 1'b0;
            else if (tick && rx_s)  armed <= 1'b1;

            case (state)
                START: begin
                    if (bit_end) begin
                        idx      <= '0;
                        perr     <= 1'b0;
                        ferr     <= 1'b0;
                        stop_idx <= 1'b0;
                    end
                end
                DATA: begin
                    if (sample) shift[idx] <= bit_val;
                    if (bit_end && idx != IDX_LAST) idx <= idx + 1'b1;
                end
                PARITY: begin
                    if (sample) perr <= ((^shift) ^ bit_val) != PAR_ODD;
                end
                STOP: begin
                    if (sample) ferr <= ferr_n;
                    if (done) begin
                        data_out   <= shift;
                        parity_err <= perr;
                        frame_err  <= ferr_n;
                        valid      <= 1'b1;
                    end
                    if (bit_end) stop_idx <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed bench for uart_rx_os16 at OS_DIV=1 (16 clk per bit); covers both sampling builds.
module tb_uart_rx_os16;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       rx_p = 1'b1;
    logic [7:0] data_out, data_out_p;
    logic       valid, parity_err, frame_err, busy;
    logic       valid_p, parity_err_p, frame_err_p, busy_p;

    int total = 0;
    int bad   = 0;
    int vcnt  = 0;
    int vcnt_p = 0;
    int dbl   = 0;
    logic prev_valid = 1'b0;
    logic [9:0] capq[$];

    uart_rx_os16 #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000)) dut (
        .clk(clk), .rst(rst), .rx(rx), .data_out(data_out), .valid(valid),
        .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
    );

    uart_rx_os16 #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .PARITY_ON(1), .PARITY_ODD(1)) dut_p (
        .clk(clk), .rst(rst), .rx(rx_p), .data_out(data_out_p), .valid(valid_p),
        .parity_err(parity_err_p), .frame_err(frame_err_p), .busy(busy_p)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid) begin
            vcnt = vcnt + 1;
            capq.push_back({parity_err, frame_err, data_out});
        end
        if (valid && prev_valid) dbl = dbl + 1;
        prev_valid = valid;
        if (valid_p) vcnt_p = vcnt_p + 1;
    end

    task automatic wait_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int which, input logic b);
        if (which == 0) rx = b;
        else            rx_p = b;
    endtask

    task automatic send_bit(input int which, input logic b);
        drive(which, b);
        wait_clk(16);
    endtask

    task automatic send_frame(input int which, input logic [7:0] d, input bit has_par,
                              input logic pbit, input logic stopv);
        send_bit(which, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(which, d[i]);
        if (has_par) send_bit(which, pbit);
        send_bit(which, stopv);
    endtask

    initial begin
        int v0;
        logic [9:0] c;

        wait_clk(3);
        check("rst_data", data_out, 8'h00);
        check("rst_valid", valid, 1'b0);
        check("rst_perr", parity_err, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        wait_clk(32);

        // 1: plain frame
        v0 = vcnt;
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        wait_clk(16);
        check("s1_count", vcnt - v0, 1);
        check("s1_data", data_out, 8'hA5);
        check("s1_perr", parity_err, 1'b0);
        check("s1_ferr", frame_err, 1'b0);
        check("s1_busy", busy, 1'b0);

        // 2: odd parity instance
        v0 = vcnt_p;
        send_frame(1, 8'h03, 1'b1, 1'b1, 1'b1);
        wait_clk(16);
        check("s2a_count", vcnt_p - v0, 1);
        check("s2a_perr", parity_err_p, 1'b0);
        check("s2a_data", data_out_p, 8'h03);
        send_frame(1, 8'h03, 1'b1, 1'b0, 1'b1);
        wait_clk(16);
        check("s2b_count", vcnt_p - v0, 2);
        check("s2b_perr", parity_err_p, 1'b1);
        check("s2b_data", data_out_p, 8'h03);
        check("s2_ferr", frame_err_p, 1'b0);

        // 3: framing error then break
        v0 = vcnt;
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
        wait_clk(16 * 40);
        check("s3_count", vcnt - v0, 1);
        check("s3_ferr", frame_err, 1'b1);
        check("s3_data", data_out, 8'h3C);
        check("s3_busy_low", busy, 1'b0);
        rx = 1'b1;
        wait_clk(48);
        check("s3_count_after", vcnt - v0, 1);
        check("s3_busy_after", busy, 1'b0);

        // 4: short low glitch
        v0 = vcnt;
        rx = 1'b0;
        wait_clk(5);
        rx = 1'b1;
        wait_clk(11);
        check("s4_busy", busy, 1'b0);
        wait_clk(300);
        check("s4_count", vcnt - v0, 0);

        // 5: back-to-back
        capq.delete();
        send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1);
        wait_clk(32);
        check("s5_count", capq.size(), 3);
        c = (capq.size() > 0) ? capq.pop_front() : 10'h3FF;
        check("s5_f0", c, {2'b00, 8'h00});
        c = (capq.size() > 0) ? capq.pop_front() : 10'h3FF;
        check("s5_f1", c, {2'b00, 8'hFF});
        c = (capq.size() > 0) ? capq.pop_front() : 10'h3FF;
        check("s5_f2", c, {2'b00, 8'h81});

        // 6: reset mid-frame
        v0 = vcnt;
        send_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(0, i[0] ? 1'b1 : 1'b0); // 0x5A bits 0..3 = 0,1,0,1
        rx = 1'b1;                                                   // bit 4 of 0x5A
        wait_clk(8);
        rst = 1'b1;
        wait_clk(3);
        check("s6_busy_rst", busy, 1'b0);
        rst = 1'b0;
        wait_clk(100);
        check("s6_count_abort", vcnt - v0, 0);
        check("s6_data_rst", data_out, 8'h00);
        send_frame(0, 8'h12, 1'b0, 1'b0, 1'b1);
        wait_clk(16);
        check("s6_count", vcnt - v0, 1);
        check("s6_data", data_out, 8'h12);

`ifdef UART_RX_MAJORITY_EN
        // 1-clk low glitch captured at sub==8 of data bit 0
        v0 = vcnt;
        send_bit(0, 1'b0);
        rx = 1'b1;
        wait_clk(9);
        rx = 1'b0;
        wait_clk(1);
        rx = 1'b1;
        wait_clk(6);
        for (int i = 1; i < 8; i++) send_bit(0, 1'b1);
        send_bit(0, 1'b1);
        wait_clk(16);
        check("maj_count", vcnt - v0, 1);
        check("maj_data", data_out, 8'hFF);
`endif

        check("no_double_valid", dbl, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
